// File: rtl/inst_buffer.sv
// inst_buffer: circular instruction FIFO between fetch and dispatch.
// Up to N packets are pushed per cycle at tail, and up to N are presented from head.
// Dispatch retires any number of the presented packets; a restore flushes everything.
// Optional same-cycle fetch-to-dispatch bypass when empty: define INST_BUFFER_BYPASS_EN.

module inst_buffer_lane #(
  parameter int PKT_W = 32
) (
  input  logic [PKT_W-1:0] stored_pkt,
  input  logic [PKT_W-1:0] fetch_pkt,
  input  logic             use_fetch,
  input  logic             lane_en,
  output logic [PKT_W-1:0] out_pkt
);
  // Pick the stored or bypassed packet for this slot; unused slots read as zero
  always_comb begin
    out_pkt = '0;
    if (lane_en) out_pkt = use_fetch ? fetch_pkt : stored_pkt;
  end
endmodule

module inst_buffer #(
  parameter int N     = 2,
  parameter int DEPTH = 8,
  parameter int PKT_W = 32
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [N-1:0][PKT_W-1:0]        fetch_packets,
  input  logic [$clog2(N+1)-1:0]         num_fetched,
  input  logic [$clog2(N+1)-1:0]         num_dispatched,
  input  logic                           restore_valid,
  output logic [N-1:0][PKT_W-1:0]        instructions_out,
  output logic [$clog2(N+1)-1:0]         instructions_valid,
  output logic [$clog2(N+1)-1:0]         ib_spots
);
  localparam int CW   = $clog2(N+1);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int XW   = CNTW + 1;  // headroom for count + push arithmetic

  logic [PW-1:0]    head, tail;
  logic [CNTW-1:0]  count;
  logic [PKT_W-1:0] mem [DEPTH];

  logic [XW-1:0] count_x, free_x, spots_x, fetched_x, disp_x;
  logic [XW-1:0] push_x, valid_x, pop_x, skip_x;
  logic          byp;

  // Spots come from registered count only, so a same-cycle pop never frees room for a push
  assign count_x   = XW'(count);
  assign free_x    = XW'(DEPTH) - count_x;
  assign spots_x   = (free_x < XW'(N)) ? free_x : XW'(N);
  assign fetched_x = XW'(num_fetched);
  assign disp_x    = XW'(num_dispatched);
  assign push_x    = (fetched_x < spots_x) ? fetched_x : spots_x;

`ifdef INST_BUFFER_BYPASS_EN
  // Empty buffer forwards the incoming packets straight to dispatch
  assign byp = (count == '0) && !restore_valid;
`else
  assign byp = 1'b0;
`endif

  assign valid_x = byp ? push_x : ((count_x < XW'(N)) ? count_x : XW'(N));
  assign pop_x   = (disp_x < valid_x) ? disp_x : valid_x;
  // Bypassed packets that dispatch consumes never touch storage
  assign skip_x  = byp ? pop_x : '0;

  assign instructions_valid = CW'(valid_x);
  assign ib_spots           = CW'(spots_x);

  for (genvar i = 0; i < N; i++) begin : g_lane
    inst_buffer_lane #(.PKT_W(PKT_W)) u_lane (
      .stored_pkt (mem[head + PW'(i)]),
      .fetch_pkt  (fetch_packets[i]),
      .use_fetch  (byp),
      .lane_en    (XW'(i) < valid_x),
      .out_pkt    (instructions_out[i])
    );
  end

  // Write accepted fetch packets at tail onward, minus any consumed through the bypass
  always_ff @(posedge clock) begin
    if (!reset && !restore_valid) begin
      for (int i = 0; i < N; i++) begin
        if (XW'(i) >= skip_x && XW'(i) < push_x)
          mem[tail + PW'(XW'(i) - skip_x)] <= fetch_packets[i];
      end
    end
  end

  // Advance pointers and occupancy; reset and restore both empty the buffer
  always_ff @(posedge clock) begin
    if (reset || restore_valid) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_x - skip_x);
      tail  <= tail + PW'(push_x - skip_x);
      count <= CNTW'(count_x + push_x - pop_x);
    end
  end
endmodule

// File: tb/tb_inst_buffer.sv
// Self-checking bench for inst_buffer (N=2, DEPTH=8) with a queue scoreboard.
module tb_inst_buffer;
  localparam int N = 2, DEPTH = 8, PKT_W = 32, CW = $clog2(N+1);

  logic clock = 1'b0;
  logic reset;
  logic [N-1:0][PKT_W-1:0] fetch_packets, instructions_out;
  logic [CW-1:0] num_fetched, num_dispatched, instructions_valid, ib_spots;
  logic restore_valid;

  int n_tests = 0, n_fail = 0;
  logic [PKT_W-1:0] sb[$];

  always #5 clock = ~clock;

  inst_buffer #(.N(N), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
    .clock(clock), .reset(reset), .fetch_packets(fetch_packets),
    .num_fetched(num_fetched), .num_dispatched(num_dispatched),
    .restore_valid(restore_valid), .instructions_out(instructions_out),
    .instructions_valid(instructions_valid), .ib_spots(ib_spots));

  function automatic int min2(int a, int b);
    return (a < b) ? a : b;
  endfunction

  // Expected valid count for the current state and inputs
  function automatic int model_valid();
`ifdef INST_BUFFER_BYPASS_EN
    if (sb.size() == 0 && !restore_valid)
      return min2(int'(num_fetched), min2(DEPTH - sb.size(), N));
`endif
    return min2(sb.size(), N);
  endfunction

  function automatic logic [PKT_W-1:0] exp_out(int i);
    if (i >= model_valid()) return '0;
`ifdef INST_BUFFER_BYPASS_EN
    if (sb.size() == 0 && !restore_valid) return fetch_packets[i];
`endif
    return sb[i];
  endfunction

  task automatic set_in(input int nf, input logic [PKT_W-1:0] p0, input logic [PKT_W-1:0] p1,
                        input int nd, input bit rv);
    num_fetched      = CW'(nf);
    fetch_packets[0] = p0;
    fetch_packets[1] = p1;
    num_dispatched   = CW'(nd);
    restore_valid    = rv;
  endtask

  // Apply the current inputs to the scoreboard and advance one clock
  task automatic tick();
    int spots, push, valid, pop;
    spots = min2(DEPTH - sb.size(), N);
    push  = min2(int'(num_fetched), spots);
    valid = model_valid();
    pop   = min2(int'(num_dispatched), valid);
    if (reset || restore_valid) sb.delete();
    else begin
      for (int i = 0; i < push; i++) sb.push_back(fetch_packets[i]);
      repeat (pop) void'(sb.pop_front());
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1; set_in(0, 0, 0, 0, 0); tick(); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      n_tests++; if (instructions_valid !== 2'd0) begin n_fail++; $display("FAIL reset_valid c%0d: got %0d want 0", c, instructions_valid); end
      n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL reset_spots c%0d: got %0d want 2", c, ib_spots); end
      n_tests++; if (instructions_out !== '0) begin n_fail++; $display("FAIL reset_out c%0d: got %h want 0", c, instructions_out); end
      tick();
    end
  endtask

  task automatic test_push_pop();
    set_in(2, 32'h1000, 32'h1004, 0, 0); tick();
    set_in(0, 0, 0, 1, 0); #1;
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL pp_valid1: got %0d want 2", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'h1000) begin n_fail++; $display("FAIL pp_out0: got %h want 1000", instructions_out[0]); end
    n_tests++; if (instructions_out[1] !== 32'h1004) begin n_fail++; $display("FAIL pp_out1: got %h want 1004", instructions_out[1]); end
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (instructions_valid !== 2'd1) begin n_fail++; $display("FAIL pp_valid2: got %0d want 1", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'h1004) begin n_fail++; $display("FAIL pp_out0b: got %h want 1004", instructions_out[0]); end
    n_tests++; if (instructions_out[1] !== '0) begin n_fail++; $display("FAIL pp_out1b: got %h want 0", instructions_out[1]); end
    set_in(0, 0, 0, 1, 0); tick();
  endtask

  task automatic test_fill();
    for (int c = 0; c < 4; c++) begin
      set_in(2, 32'h2000 + 8*c, 32'h2004 + 8*c, 0, 0); #1;
      n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL fill_spots c%0d: got %0d want 2", c, ib_spots); end
      tick();
    end
    set_in(2, 32'hdead, 32'hbeef, 0, 0); #1;
    n_tests++; if (ib_spots !== 2'd0) begin n_fail++; $display("FAIL full_spots: got %0d want 0", ib_spots); end
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL full_valid: got %0d want 2", instructions_valid); end
    tick();
    set_in(2, 32'hdead, 32'hbeef, 2, 0); #1;
    n_tests++; if (instructions_out[0] !== 32'h2000) begin n_fail++; $display("FAIL full_out0: got %h want 2000", instructions_out[0]); end
    n_tests++; if (ib_spots !== 2'd0) begin n_fail++; $display("FAIL full_spots2: got %0d want 0", ib_spots); end
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL after_pop_spots: got %0d want 2", ib_spots); end
    for (int c = 0; c < 3; c++) begin
      set_in(0, 0, 0, 2, 0); #1;
      n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL drain_valid c%0d: got %0d want 2", c, instructions_valid); end
      n_tests++; if (instructions_out[0] !== 32'h2008 + 8*c) begin n_fail++; $display("FAIL drain_out0 c%0d: got %h want %h", c, instructions_out[0], 32'h2008 + 8*c); end
      n_tests++; if (instructions_out[1] !== exp_out(1)) begin n_fail++; $display("FAIL drain_out1 c%0d: got %h want %h", c, instructions_out[1], exp_out(1)); end
      tick();
    end
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (instructions_valid !== 2'd0) begin n_fail++; $display("FAIL drain_empty: got %0d want 0", instructions_valid); end
  endtask

  task automatic test_wrap();
    logic [PKT_W-1:0] exp_pc, pc_in;
    int v;
    exp_pc = 32'h4000; pc_in = 32'h4000;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) set_in(2, pc_in, pc_in + 4, 2, 0);
      else        set_in(0, 0, 0, 2, 0);
      #1;
      v = int'(instructions_valid);
      n_tests++; if (v != model_valid()) begin n_fail++; $display("FAIL wrap_valid c%0d: got %0d want %0d", c, v, model_valid()); end
      for (int i = 0; i < N; i++) begin
        n_tests++;
        if (i < v && instructions_out[i] !== 32'(exp_pc + 4*i)) begin
          n_fail++; $display("FAIL wrap_pc c%0d l%0d: got %h want %h", c, i, instructions_out[i], 32'(exp_pc + 4*i));
        end else if (i >= v && instructions_out[i] !== '0) begin
          n_fail++; $display("FAIL wrap_idle c%0d l%0d: got %h want 0", c, i, instructions_out[i]);
        end
      end
      exp_pc = 32'(exp_pc + 4*v);
      if (c < 20) pc_in = pc_in + 8;
      tick();
    end
    n_tests++; if (exp_pc !== pc_in) begin n_fail++; $display("FAIL wrap_total: got %h want %h", exp_pc, pc_in); end
  endtask

  task automatic test_flush();
    set_in(2, 32'h5000, 32'h5004, 0, 0); tick();
    set_in(2, 32'h5008, 32'h500c, 0, 0); tick();
    set_in(1, 32'h5010, 0, 0, 0); tick();
    set_in(2, 32'h6000, 32'h6004, 1, 1); #1;
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL flush_cur_valid: got %0d want 2", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'h5000) begin n_fail++; $display("FAIL flush_cur_out0: got %h want 5000", instructions_out[0]); end
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (instructions_valid !== 2'd0) begin n_fail++; $display("FAIL flush_valid: got %0d want 0", instructions_valid); end
    n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL flush_spots: got %0d want 2", ib_spots); end
    n_tests++; if (instructions_out !== '0) begin n_fail++; $display("FAIL flush_out: got %h want 0", instructions_out); end
    set_in(1, 32'h7000, 0, 0, 0); tick();
    set_in(0, 0, 0, 1, 0); #1;
    n_tests++; if (instructions_valid !== 2'd1) begin n_fail++; $display("FAIL postflush_valid: got %0d want 1", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'h7000) begin n_fail++; $display("FAIL postflush_out0: got %h want 7000", instructions_out[0]); end
    n_tests++; if (instructions_out[1] !== '0) begin n_fail++; $display("FAIL postflush_out1: got %h want 0", instructions_out[1]); end
    tick();
  endtask

  task automatic test_bypass();
    set_in(2, 32'hc0, 32'hd0, 1, 0); #1;
`ifdef INST_BUFFER_BYPASS_EN
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL byp_valid0: got %0d want 2", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'hc0) begin n_fail++; $display("FAIL byp_out0: got %h want c0", instructions_out[0]); end
`else
    n_tests++; if (instructions_valid !== 2'd0) begin n_fail++; $display("FAIL nobyp_valid0: got %0d want 0", instructions_valid); end
    n_tests++; if (instructions_out !== '0) begin n_fail++; $display("FAIL nobyp_out: got %h want 0", instructions_out); end
`endif
    tick();
    set_in(0, 0, 0, 0, 0); #1;
`ifdef INST_BUFFER_BYPASS_EN
    n_tests++; if (instructions_valid !== 2'd1) begin n_fail++; $display("FAIL byp_valid1: got %0d want 1", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'hd0) begin n_fail++; $display("FAIL byp_out1: got %h want d0", instructions_out[0]); end
`else
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL nobyp_valid1: got %0d want 2", instructions_valid); end
    n_tests++; if (instructions_out[0] !== 32'hc0 || instructions_out[1] !== 32'hd0) begin n_fail++; $display("FAIL nobyp_out1: got %h want d0_c0", instructions_out); end
`endif
    set_in(0, 0, 0, 2, 0); tick();
  endtask

  task automatic test_clip();
    set_in(3, 32'h8000, 32'h8004, 0, 0); #1;
    n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL clip_spots: got %0d want 2", ib_spots); end
    tick();
    set_in(0, 0, 0, 3, 0); #1;
    n_tests++; if (instructions_valid !== 2'd2) begin n_fail++; $display("FAIL clip_valid: got %0d want 2", instructions_valid); end
    n_tests++; if (instructions_out[1] !== 32'h8004) begin n_fail++; $display("FAIL clip_out1: got %h want 8004", instructions_out[1]); end
    tick();
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (instructions_valid !== 2'd0 || sb.size() != 0) begin n_fail++; $display("FAIL clip_empty: got %0d want 0", instructions_valid); end
  endtask

  task automatic test_reset_mid();
    set_in(2, 32'h9000, 32'h9004, 0, 0); tick();
    set_in(2, 32'h9008, 32'h900c, 0, 0); tick();
    reset = 1'b1; set_in(2, 32'h9010, 32'h9014, 1, 0); tick(); reset = 1'b0;
    set_in(0, 0, 0, 0, 0); #1;
    n_tests++; if (instructions_valid !== 2'd0) begin n_fail++; $display("FAIL rmid_valid: got %0d want 0", instructions_valid); end
    n_tests++; if (ib_spots !== 2'd2) begin n_fail++; $display("FAIL rmid_spots: got %0d want 2", ib_spots); end
    n_tests++; if (instructions_out !== '0) begin n_fail++; $display("FAIL rmid_out: got %h want 0", instructions_out); end
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0);
    test_reset();
    test_push_pop();
    test_fill();
    test_wrap();
    test_flush();
    test_bypass();
    test_clip();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

- Circular FIFO between fetch and dispatch in the R10K out-of-order core.
- Accepts up to N fetched instructions per cycle, in program order, and holds them.
- Presents the oldest up to N instructions plus a valid count to dispatch.
- Retires the number dispatch actually takes, and flushes completely on a branch-mispredict restore.

## Interface
Parameters:
- N, default 2: superscalar width; maximum push and pop per cycle.
- DEPTH, default 8: number of entries; power of two, ≥ 2N.

Ports (CW = $clog2(N+1)):
- clock  in  1  system clock.
- reset  in  1  reset; one clock, synchronous and active-high.
- fetch_packets  in  N×FETCH_PACKET  incoming instructions; [0] is oldest.
- num_fetched  in  CW  count of valid entries in fetch_packets (low indices).
- num_dispatched  in  CW  number of entries dispatch consumes this cycle.
- restore_valid  in  1  branch-stack restore; flush request.
- instructions_out  out  N×FETCH_PACKET  oldest entries; [0] is oldest; unused slots are '0.
- instructions_valid  out  CW  count of valid entries in instructions_out.
- ib_spots  out  CW  pushes fetch may perform this cycle; equals min(DEPTH − count, N).

## Operation
State:
- head and tail pointers, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
- count, $clog2(DEPTH+1) bits.
- Entry storage array.

Pop:
- eff_pop = min(num_dispatched, instructions_valid); excess is silently clipped.
- head advances by eff_pop.

Push:
- eff_push = min(num_fetched, ib_spots); excess is silently clipped.
- Entries are written at tail, tail+1, … with wrap.
- tail advances by eff_push.

Count and output limits:
- count_next = count + eff_push − eff_pop.
- instructions_valid = min(count, N).
- instructions_out[i] = entry[head+i] for i < instructions_valid, else '0.

Full, empty, and concurrent events:
- ib_spots is computed from registered count only. A same-cycle pop does not free spots for a same-cycle push.
- When full, ib_spots = 0. When empty, instructions_valid = 0.
- Push and pop in the same cycle are both applied.

Flush:
- restore_valid = 1: next cycle head = tail = count = 0. The same-cycle push and pop are ignored.
- Outputs are still driven from current state in that cycle.

Reset:
- Same effect as restore_valid, with priority over it.
- Storage contents are don't-care.
- Outputs after reset: instructions_valid = 0, instructions_out = '0, ib_spots = N.

## Timing
- Push-to-visible latency: 1 cycle. An entry written at edge k appears on instructions_out after edge k.
- All outputs are combinational from registered state only, except in bypass mode.
- No combinational path exists from num_dispatched or num_fetched to any output, except in bypass mode.
- Dispatch derives num_dispatched combinationally from instructions_valid in the same cycle. This is legal because instructions_valid does not depend on num_dispatched.
- Reset mid-operation discards all contents at that edge.

## Configuration
- Macro: INST_BUFFER_BYPASS_EN.
- Defined, with count == 0 and restore_valid == 0:
  - instructions_out[i] = fetch_packets[i] for i < eff_push.
  - instructions_valid = eff_push.
  - The first eff_pop fetched entries are not written to storage; the rest are written at tail.
  - Latency is 0 cycles when empty.
  - This creates a combinational path num_fetched → instructions_valid.
- Defined, in all other cycles: behaviour is identical to the undefined case.
- Undefined: no bypass; latency is always 1 cycle.

## Test plan
1. Reset, then idle:
   - instructions_valid = 0, ib_spots = 2.
   - After 3 cycles of no activity, state is unchanged.
2. Push A,B at cycle 0, then pop 1 at cycle 1:
   - Cycle 1: instructions_out = {A,B}, valid = 2.
   - Cycle 2: instructions_out[0] = B, valid = 1.
3. Fill to DEPTH = 8 with 2/cycle and no pops:
   - After 4 pushes, ib_spots = 0.
   - A further num_fetched = 2 is dropped; count stays 8.
   - Pop 2 and push 2 in the same cycle: push is dropped; count = 6.
4. Wrap-around: 20 cycles of push 2 / pop 2 with sequential PCs:
   - Output PCs are strictly in order across the pointer wrap at entry 7→0.
5. Flush: count = 5, restore_valid = 1 with push 2 and pop 1:
   - Next cycle count = 0, valid = 0, ib_spots = 2.
   - A push in the following cycle appears at [0].
6. Bypass (INST_BUFFER_BYPASS_EN defined), buffer empty:
   - Push C,D with pop 1: same cycle instructions_out[0] = C, valid = 2.
   - Next cycle instructions_out[0] = D, valid = 1.
   - With the macro undefined, the same stimulus gives valid = 0 in that cycle, then C,D next cycle.
